// File: rtl/pipelined_carry_adder.sv
// WIDTH-bit add/subtract split into CHUNK-bit carry-propagate slices, one slice per stage,
// behind a valid/ready pipeline that stalls as a whole when the output is blocked.
module pipelined_carry_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  logic             en;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign b_eff    = sub ? ~b : b;
  assign c0       = sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0]       op_a;
    logic [CHUNK-1:0]       op_b;
    logic                   c_in;
    logic                   v_in;
    logic [CHUNK:0]         part;
    logic [(k+1)*CHUNK-1:0] s_d;
    logic [(k+1)*CHUNK-1:0] s_q;
    logic                   c_q;
    logic                   v_q;

    assign part = {1'b0, op_a} + {1'b0, op_b} + {{CHUNK{1'b0}}, c_in};

    if (k == 0) begin : g_head
      assign op_a = a[CHUNK-1:0];
      assign op_b = b_eff[CHUNK-1:0];
      assign c_in = c0;
      assign v_in = accept;
      assign s_d  = part[CHUNK-1:0];
    end else begin : g_body
      assign op_a = g_stage[k-1].g_skew.a_q[CHUNK-1:0];
      assign op_b = g_stage[k-1].g_skew.b_q[CHUNK-1:0];
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      // Lower result chunks ride along so the whole word leaves in one beat.
      assign s_d  = {part[CHUNK-1:0], g_stage[k-1].s_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        if (v_in) begin
          c_q <= part[CHUNK];
          s_q <= s_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned SW = WIDTH - (k + 1) * CHUNK;
      logic [SW-1:0] a_d;
      logic [SW-1:0] b_d;
      logic [SW-1:0] a_q;
      logic [SW-1:0] b_q;

      if (k == 0) begin : g_src_in
        assign a_d = a[WIDTH-1:CHUNK];
        assign b_d = b_eff[WIDTH-1:CHUNK];
      end else begin : g_src_prev
        assign a_d = g_stage[k-1].g_skew.a_q[SW+CHUNK-1:CHUNK];
        assign b_d = g_stage[k-1].g_skew.b_q[SW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en && v_in) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // The top slice still holds the operand MSBs, so overflow is resolved here.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en && v_in) begin
          ovf_q <= (op_a[CHUNK-1] == op_b[CHUNK-1]) && (part[CHUNK-1] != op_a[CHUNK-1]);
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Self-checking bench for pipelined_carry_adder: table vectors, random stream with
// back-pressure, stall/drain, mid-stream reset, and three extra parameter sets.
module tb_pipelined_carry_adder;

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          stamp;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] a, b, sum;

  logic        x_valid, x_ready, x_cin, x_sub;
  logic [31:0] x_a, x_b;
  logic        r32_in_ready, r32_out_valid, r32_cout, r32_ovf;
  logic [31:0] r32_sum;
  logic        r16_in_ready, r16_out_valid, r16_cout, r16_ovf;
  logic [15:0] r16_sum;
  logic        r8_in_ready, r8_out_valid, r8_cout, r8_ovf;
  logic [7:0]  r8_sum;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rx = 0;
  int   waited, n, rx_start, rx_mark;
  bit   lat_chk = 1'b0;
  bit   acc_seen = 1'b0;
  exp_t pend;
  exp_t q[$];
  exp_t q32[$];
  exp_t q16[$];
  exp_t q8[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  pipelined_carry_adder #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  pipelined_carry_adder #(.WIDTH(32), .CHUNK(32)) dut_w32c32 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r32_in_ready), .a(x_a),
    .b(x_b), .cin(x_cin), .sub(x_sub), .out_valid(r32_out_valid), .out_ready(x_ready),
    .sum(r32_sum), .cout(r32_cout), .ovf(r32_ovf)
  );

  pipelined_carry_adder #(.WIDTH(16), .CHUNK(4)) dut_w16c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r16_in_ready), .a(x_a[15:0]),
    .b(x_b[15:0]), .cin(x_cin), .sub(x_sub), .out_valid(r16_out_valid), .out_ready(x_ready),
    .sum(r16_sum), .cout(r16_cout), .ovf(r16_ovf)
  );

  pipelined_carry_adder #(.WIDTH(8), .CHUNK(1)) dut_w8c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(x_valid), .in_ready(r8_in_ready), .a(x_a[7:0]),
    .b(x_b[7:0]), .cin(x_cin), .sub(x_sub), .out_valid(r8_out_valid), .out_ready(x_ready),
    .sum(r8_sum), .cout(r8_cout), .ovf(r8_ovf)
  );

  // Golden model from integer arithmetic: unsigned for sum/cout, signed range for ovf.
  function automatic exp_t model(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                 input logic ic, input logic is, input int stamp);
    exp_t        e;
    longint      ua, ub, sa, sb, ci, half, r, res;
    logic [63:0] m, rbits;
    m    = (64'd1 << w) - 64'd1;
    ua   = longint'({32'd0, ia} & m);
    ub   = longint'({32'd0, ib} & m);
    half = longint'(1) << (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    ci   = ic ? 1 : 0;
    if (is) begin
      r      = sa - sb - ci;
      res    = ua - ub - ci;
      e.cout = (ua >= ub + ci);
    end else begin
      r      = sa + sb + ci;
      res    = ua + ub + ci;
      e.cout = ((res >> w) != 0);
    end
    rbits   = 64'(res) & m;
    e.sum   = rbits[31:0];
    e.ovf   = (r >= half) || (r < -half);
    e.stamp = stamp;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic dc,
                       input logic ds);
    in_valid = 1'b1;
    a        = da;
    b        = db;
    cin      = dc;
    sub      = ds;
    pend     = model(32, da, db, dc, ds, 0);
  endtask

  task automatic rand_side();
    out_ready = 1'($urandom_range(1));
    x_valid   = ($urandom_range(9) < 7);
    x_a       = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
    x_b       = ($urandom_range(7) == 0) ? 32'h0000_0001 : $urandom;
    x_cin     = 1'($urandom_range(1));
    x_sub     = 1'($urandom_range(1));
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    acc_seen = in_valid && in_ready;
    if (acc_seen) begin
      e       = pend;
      e.stamp = cyc;
      q.push_back(e);
    end
    if (out_valid && out_ready) begin
      check("main beat expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        rx++;
        check("main result", {ovf, cout, sum}, {e.ovf, e.cout, e.sum});
        if (lat_chk) check("main latency", cyc - e.stamp, 4);
      end
    end
    if (x_valid && r32_in_ready) q32.push_back(model(32, x_a, x_b, x_cin, x_sub, cyc));
    if (x_valid && r16_in_ready) q16.push_back(model(16, x_a, x_b, x_cin, x_sub, cyc));
    if (x_valid && r8_in_ready) q8.push_back(model(8, x_a, x_b, x_cin, x_sub, cyc));
    if (r32_out_valid) begin
      check("w32c32 beat expected", q32.size() != 0, 1);
      if (q32.size() != 0) begin
        e = q32.pop_front();
        check("w32c32 result", {r32_ovf, r32_cout, r32_sum}, {e.ovf, e.cout, e.sum});
        check("w32c32 latency", cyc - e.stamp, 1);
      end
    end
    if (r16_out_valid) begin
      check("w16c4 beat expected", q16.size() != 0, 1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("w16c4 result", {r16_ovf, r16_cout, r16_sum}, {e.ovf, e.cout, e.sum[15:0]});
        check("w16c4 latency", cyc - e.stamp, 4);
      end
    end
    if (r8_out_valid) begin
      check("w8c1 beat expected", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("w8c1 result", {r8_ovf, r8_cout, r8_sum}, {e.ovf, e.cout, e.sum[7:0]});
        check("w8c1 latency", cyc - e.stamp, 8);
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic drain(input int lim);
    in_valid  = 1'b0;
    x_valid   = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < lim && (q.size() + q32.size() + q16.size() + q8.size()) != 0; i++)
      tick();
    check("drain all queues", q.size() + q32.size() + q16.size() + q8.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
    vecs[6] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[8] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    rst_n = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    x_valid = 1'b0; x_ready = 1'b1; x_a = '0; x_b = '0; x_cin = 1'b0; x_sub = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset cout/ovf", {cout, ovf}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("in_ready after reset", in_ready, 1);

    // Boundary vectors back-to-back with a free output: latency must be exactly 4.
    lat_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      pend.sum  = vecs[i].sum;
      pend.cout = vecs[i].cout;
      pend.ovf  = vecs[i].ovf;
      tick();
      check("table accept", acc_seen, 1);
    end
    drain(20);
    lat_chk = 1'b0;

    // Random stream with bubbles and random back-pressure; extra instances run alongside.
    rx_start = rx;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        rand_side();
        tick();
      end
      drive(32'(i * 12345), 32'(i * 777), 1'($urandom_range(1)), 1'($urandom_range(1)));
      waited = 0;
      acc_seen = 1'b0;
      do begin
        rand_side();
        tick();
        waited++;
      end while (!acc_seen && waited < 100);
      check("stream accept", acc_seen, 1);
    end
    drain(100);
    check("stream count", rx - rx_start, 1000);

    // Fill the pipe against a blocked output, hold, then release.
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      drive(32'(n) * 32'h0101_0101, 32'h00FF_00FF, 1'b0, 1'(n & 1));
      tick();
      n++;
    end
    check("beats to fill", n, 4);
    check("full in_ready", in_ready, 0);
    drive(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) begin
      tick();
      check("stall no accept", acc_seen, 0);
      check("stall in_ready", in_ready, 0);
      check("stall out_valid", out_valid, 1);
      check("stall sum", sum, q[0].sum);
    end
    out_ready = 1'b1;
    tick();
    check("release accept", acc_seen, 1);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("drain streak", out_valid, 1);
      tick();
    end
    check("pipe empty", out_valid, 0);
    drain(10);

    // Asynchronous reset with beats in flight: nothing stale may emerge afterwards.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(32'(32'h1111_1111 * (k + 1)), 32'h0000_0002, 1'b0, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    rx_mark = rx;
    check("pre-reset out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset sum", sum, 0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("in_ready after release", in_ready, 1);
    repeat (10) tick();
    check("no stale beats", rx - rx_mark, 0);
    drain(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
